// File: rtl/ucsbece154a_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154a_mem_arbiter
// Purpose  : N-port arbiter and wait-state controller in front of the single
//            unified memory. It serialises master requests onto one memory
//            port, stretches each access by WAIT_STATES cycles, and returns
//            registered read data plus a one-cycle ack to the served master.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1            rising-edge clock
//   reset      in   1            asynchronous active-low reset
//   req_i      in   NPORTS       per-master request, held until ack
//   we_i       in   NPORTS       per-master write enable
//   adr_i      in   NPORTS*AW    packed addresses, port k at [k*AW +: AW]
//   wd_i       in   NPORTS*DW    packed write data, port k at [k*DW +: DW]
//   gnt_o      out  NPORTS       one-hot owner of the memory port
//   ack_o      out  NPORTS       one-cycle completion pulse to the owner
//   rd_o       out  DW           registered read data, held after ack
//   mem_we_o   out  1            memory write strobe
//   mem_a_o    out  AW           memory address
//   mem_wd_o   out  DW           memory write data
//   mem_rd_i   in   DW           memory read data (combinational from mem_a_o)
// Configuration
//   UCSBECE154A_ARB_FIXED_PRIO_EN  defined  : lowest-index requester wins
//                                  undefined: round-robin from a pointer
// ============================================================================
module ucsbece154a_mem_arbiter #(
    parameter int NPORTS      = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    req_i,
    input  logic [NPORTS-1:0]    we_i,
    input  logic [NPORTS*AW-1:0] adr_i,
    input  logic [NPORTS*DW-1:0] wd_i,
    output logic [NPORTS-1:0]    gnt_o,
    output logic [NPORTS-1:0]    ack_o,
    output logic [DW-1:0]        rd_o,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_a_o,
    output logic [DW-1:0]        mem_wd_o,
    input  logic [DW-1:0]        mem_rd_i
);

    localparam int         c_PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [3:0] c_WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [NPORTS-1:0]  r_gnt_q,   w_gnt_d;
    logic               r_we_q,    w_we_d;
    logic [AW-1:0]      r_adr_q,   w_adr_d;
    logic [DW-1:0]      r_wd_q,    w_wd_d;
    logic [3:0]         r_cnt_q,   w_cnt_d;
    logic [DW-1:0]      r_rd_q,    w_rd_d;

    logic [NPORTS-1:0]  w_sel;      // one-hot winner, zero when nobody asks
    logic [AW-1:0]      w_adr_sel;
    logic [DW-1:0]      w_wd_sel;
    logic               w_we_sel;

`ifdef UCSBECE154A_ARB_FIXED_PRIO_EN
    // Isolate the lowest set request bit.
    assign w_sel = req_i & (~req_i + NPORTS'(1));
`else
    logic [c_PW-1:0]     r_ptr_q, w_ptr_d;
    logic [c_PW-1:0]     r_win_q, w_win_d;
    logic [c_PW-1:0]     w_win;
    logic [2*NPORTS-1:0] w_req_dbl;
    logic [NPORTS-1:0]   w_req_rot;
    logic [c_PW:0]       w_sum;

    // Rotate requests so the pointer position lands on bit 0, take the first
    // set bit, then map the offset back to an absolute port index.
    always_comb begin
        w_req_dbl = {req_i, req_i};
        w_req_rot = NPORTS'(w_req_dbl >> r_ptr_q);
        w_sum     = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_sum = {1'b0, r_ptr_q} + (c_PW + 1)'(i);
            end
        end
        if (w_sum >= (c_PW + 1)'(NPORTS)) begin
            w_sum = w_sum - (c_PW + 1)'(NPORTS);
        end
        w_win = w_sum[c_PW-1:0];
        w_sel = (|req_i) ? (NPORTS'(1) << w_win) : '0;
    end

    always_comb begin
        w_ptr_d = r_ptr_q;
        w_win_d = r_win_q;
        if ((r_state_q == S_IDLE) && (|req_i)) begin
            w_win_d = w_win;
        end
        if (r_state_q == S_ACK) begin
            w_ptr_d = (r_win_q == c_PW'(NPORTS - 1)) ? '0 : r_win_q + c_PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr_q <= '0;
            r_win_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
            r_win_q <= w_win_d;
        end
    end
`endif

    // Payload of the winning port (w_sel is one-hot).
    always_comb begin
        w_adr_sel = '0;
        w_wd_sel  = '0;
        w_we_sel  = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (w_sel[k]) begin
                w_adr_sel = adr_i[k*AW +: AW];
                w_wd_sel  = wd_i[k*DW +: DW];
                w_we_sel  = we_i[k];
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_gnt_d   = r_gnt_q;
        w_we_d    = r_we_q;
        w_adr_d   = r_adr_q;
        w_wd_d    = r_wd_q;
        w_cnt_d   = r_cnt_q;
        w_rd_d    = r_rd_q;
        case (r_state_q)
            S_IDLE: begin
                w_gnt_d = '0;
                if (|req_i) begin
                    w_state_d = S_BUSY;
                    w_gnt_d   = w_sel;
                    w_we_d    = w_we_sel;
                    w_adr_d   = w_adr_sel;
                    w_wd_d    = w_wd_sel;
                    w_cnt_d   = c_WS;
                end
            end
            S_BUSY: begin
                if (r_cnt_q == 4'd0) begin
                    w_rd_d    = mem_rd_i;
                    w_state_d = S_ACK;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                w_gnt_d   = '0;
                w_state_d = S_IDLE;
            end
            default: begin
                w_gnt_d   = '0;
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= S_IDLE;
            r_gnt_q   <= '0;
            r_we_q    <= 1'b0;
            r_adr_q   <= '0;
            r_wd_q    <= '0;
            r_cnt_q   <= '0;
            r_rd_q    <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_gnt_q   <= w_gnt_d;
            r_we_q    <= w_we_d;
            r_adr_q   <= w_adr_d;
            r_wd_q    <= w_wd_d;
            r_cnt_q   <= w_cnt_d;
            r_rd_q    <= w_rd_d;
        end
    end

    // The write strobe is only ever asserted in the final BUSY cycle.
    assign mem_we_o = (r_state_q == S_BUSY) && (r_cnt_q == 4'd0) && r_we_q;
    assign mem_a_o  = r_adr_q;
    assign mem_wd_o = r_wd_q;
    assign gnt_o    = r_gnt_q;
    assign ack_o    = (r_state_q == S_ACK) ? r_gnt_q : '0;
    assign rd_o     = r_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154a_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucsbece154a_mem_arbiter
// Purpose  : Directed self-checking bench. Instance B (4 ports, no wait
//            states) runs a table of vectors; instance A (2 ports, 3 wait
//            states) runs hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucsbece154a_mem_arbiter;

`ifdef UCSBECE154A_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: 2 ports, 3 wait states ----------------
    logic [1:0]  a_req, a_we, a_gnt, a_ack;
    logic [63:0] a_adr, a_wd;
    logic [31:0] a_rd, a_mem_a, a_mem_wd, a_mem_rd;
    logic        a_mem_we;

    // ---------------- instance B: 4 ports, 0 wait states ----------------
    logic [3:0]   b_req, b_we, b_gnt, b_ack;
    logic [127:0] b_adr, b_wd;
    logic [31:0]  b_rd, b_mem_a, b_mem_wd, b_mem_rd;
    logic         b_mem_we;

    ucsbece154a_mem_arbiter #(.NPORTS(2), .AW(32), .DW(32), .WAIT_STATES(3)) dut_a (
        .clk(clk), .reset(reset), .req_i(a_req), .we_i(a_we), .adr_i(a_adr), .wd_i(a_wd),
        .gnt_o(a_gnt), .ack_o(a_ack), .rd_o(a_rd), .mem_we_o(a_mem_we),
        .mem_a_o(a_mem_a), .mem_wd_o(a_mem_wd), .mem_rd_i(a_mem_rd)
    );

    ucsbece154a_mem_arbiter #(.NPORTS(4), .AW(32), .DW(32), .WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(reset), .req_i(b_req), .we_i(b_we), .adr_i(b_adr), .wd_i(b_wd),
        .gnt_o(b_gnt), .ack_o(b_ack), .rd_o(b_rd), .mem_we_o(b_mem_we),
        .mem_a_o(b_mem_a), .mem_wd_o(b_mem_wd), .mem_rd_i(b_mem_rd)
    );

    // Word-addressed memories standing in for ucsbece154a_mem.
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic        mem_init;
    assign a_mem_rd = mem_a[a_mem_a[7:2]];
    assign b_mem_rd = mem_b[b_mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] <= 32'hA500_0000 + i;
                mem_b[i] <= (i == 4) ? 32'hDEAD_BEEF : 32'hA500_0000 + i;
            end
        end else begin
            if (a_mem_we) mem_a[a_mem_a[7:2]] <= a_mem_wd;
            if (b_mem_we) mem_b[b_mem_a[7:2]] <= b_mem_wd;
        end
    end

    // Expected memory contents, maintained by the bench.
    logic [31:0] sh_a [64];
    logic [31:0] sh_b [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        we;
        logic [7:0]  base;    // port k uses base + 4*k
        logic [31:0] wd;
        logic [3:0]  gnt_rr;
        logic [3:0]  gnt_fp;
    } vec_t;

    vec_t vecs [9];

    // Single access on instance A; watches a bounded window of cycles.
    task automatic a_access(input int port, input logic we, input logic [31:0] adr,
                            input logic [31:0] wd, output int ack_cyc, output int ack_cnt,
                            output int we_cyc, output int we_cnt, output logic [31:0] we_adr,
                            output logic [31:0] rd_ack, output logic [1:0] ack_val);
        a_req = '0;
        a_req[port] = 1'b1;
        a_we[port] = we;
        a_adr[port*32 +: 32] = adr;
        a_wd[port*32 +: 32] = wd;
        ack_cyc = -1; ack_cnt = 0; we_cyc = -1; we_cnt = 0;
        we_adr = '0; rd_ack = '0; ack_val = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (a_mem_we) begin
                we_cnt++;
                we_cyc = c;
                we_adr = a_mem_a;
            end
            if (|a_ack) begin
                ack_cnt++;
                if (ack_cyc < 0) begin
                    ack_cyc = c;
                    rd_ack  = a_rd;
                    ack_val = a_ack;
                end
                a_req = '0;
            end
        end
    endtask

    initial begin
        int          win, ack_cyc, ack_cnt, we_cyc, we_cnt, n;
        logic [31:0] ea, erd, we_adr, rd_ack;
        logic [1:0]  ack_val;
        logic [3:0]  exp_g;
        logic [1:0]  acks [4];
        logic [1:0]  exp_alt [4];

        reset = 1'b0;
        mem_init = 1'b1;
        a_req = '0; a_we = '0; a_adr = '0; a_wd = '0;
        b_req = '0; b_we = '0; b_adr = '0; b_wd = '0;
        for (int i = 0; i < 64; i++) begin
            sh_a[i] = 32'hA500_0000 + i;
            sh_b[i] = (i == 4) ? 32'hDEAD_BEEF : 32'hA500_0000 + i;
        end

        //             req      we    base   wd             gnt_rr   gnt_fp
        vecs[0] = '{4'b0001, 1'b0, 8'h10, 32'h0,         4'b0001, 4'b0001};
        vecs[1] = '{4'b0010, 1'b0, 8'h20, 32'h0,         4'b0010, 4'b0010};
        vecs[2] = '{4'b1011, 1'b0, 8'h00, 32'h0,         4'b1000, 4'b0001};
        vecs[3] = '{4'b1011, 1'b0, 8'h00, 32'h0,         4'b0001, 4'b0001};
        vecs[4] = '{4'b1011, 1'b0, 8'h10, 32'h0,         4'b0010, 4'b0001};
        vecs[5] = '{4'b1000, 1'b1, 8'h30, 32'hCAFE_F00D, 4'b1000, 4'b1000};
        vecs[6] = '{4'b1000, 1'b0, 8'h30, 32'h0,         4'b1000, 4'b1000};
        vecs[7] = '{4'b0110, 1'b0, 8'h00, 32'h0,         4'b0010, 4'b0010};
        vecs[8] = '{4'b0110, 1'b0, 8'h00, 32'h0,         4'b0100, 4'b0010};

        repeat (2) @(negedge clk);
        mem_init = 1'b0;

        // Reset state
        check("rst_a_gnt", a_gnt, 0);
        check("rst_a_ack", a_ack, 0);
        check("rst_a_rd", a_rd, 0);
        check("rst_a_mem_we", a_mem_we, 0);
        check("rst_a_mem_a", a_mem_a, 0);
        check("rst_a_mem_wd", a_mem_wd, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_b_ack", b_ack, 0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven vectors on instance B
        for (int v = 0; v < 9; v++) begin
            exp_g = FP ? vecs[v].gnt_fp : vecs[v].gnt_rr;
            win = 0;
            for (int k = 0; k < 4; k++) if (exp_g[k]) win = k;
            ea  = {24'h0, vecs[v].base} + 32'(4 * win);
            erd = sh_b[ea[7:2]];
            b_req = vecs[v].req;
            b_we  = vecs[v].we ? vecs[v].req : 4'b0000;
            for (int k = 0; k < 4; k++) begin
                b_adr[k*32 +: 32] = {24'h0, vecs[v].base} + 32'(4 * k);
                b_wd[k*32 +: 32]  = vecs[v].wd;
            end
            @(negedge clk);
            check($sformatf("v%0d_busy_gnt", v), b_gnt, exp_g);
            check($sformatf("v%0d_busy_ack", v), b_ack, 0);
            check($sformatf("v%0d_mem_a", v), b_mem_a, ea);
            check($sformatf("v%0d_mem_we", v), b_mem_we, vecs[v].we);
            if (vecs[v].we) check($sformatf("v%0d_mem_wd", v), b_mem_wd, vecs[v].wd);
            @(negedge clk);
            check($sformatf("v%0d_ack", v), b_ack, exp_g);
            check($sformatf("v%0d_ack_gnt", v), b_gnt, exp_g);
            check($sformatf("v%0d_rd", v), b_rd, erd);
            check($sformatf("v%0d_ack_mem_we", v), b_mem_we, 0);
            b_req = '0;
            if (vecs[v].we) sh_b[ea[7:2]] = vecs[v].wd;
            @(negedge clk);
            check($sformatf("v%0d_idle_gnt", v), b_gnt, 0);
            check($sformatf("v%0d_idle_ack", v), b_ack, 0);
        end

        // Write with three wait states on port 1
        a_access(1, 1'b1, 32'h20, 32'h1234_5678, ack_cyc, ack_cnt, we_cyc, we_cnt, we_adr, rd_ack, ack_val);
        check("wr_we_count", we_cnt, 1);
        check("wr_we_cycle", we_cyc, 4);
        check("wr_we_addr", we_adr, 32'h20);
        check("wr_ack_cycle", ack_cyc, 5);
        check("wr_ack_count", ack_cnt, 1);
        check("wr_ack_val", ack_val, 2'b10);
        sh_a[8] = 32'h1234_5678;
        a_access(1, 1'b0, 32'h20, 32'h0, ack_cyc, ack_cnt, we_cyc, we_cnt, we_adr, rd_ack, ack_val);
        check("rb_ack_cycle", ack_cyc, 5);
        check("rb_rd", rd_ack, sh_a[8]);
        check("rb_we_count", we_cnt, 0);

        // Both ports requesting continuously
        exp_alt[0] = 2'b01;
        exp_alt[1] = FP ? 2'b01 : 2'b10;
        exp_alt[2] = 2'b01;
        exp_alt[3] = FP ? 2'b01 : 2'b10;
        a_we = 2'b00;
        a_adr = {32'h04, 32'h00};
        a_req = 2'b11;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (|a_ack) begin
                acks[n] = a_ack;
                n++;
            end
        end
        a_req = 2'b00;
        check("alt_count", n, 4);
        for (int i = 0; i < 4; i++) check($sformatf("alt_ack%0d", i), acks[i], exp_alt[i]);
        @(negedge clk);

        // Reset pulse during BUSY of a write
        a_req = 2'b01; a_we = 2'b01;
        a_adr[31:0] = 32'h20; a_wd[31:0] = 32'h55AA_55AA;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_gnt", a_gnt, 0);
        check("mid_rst_ack", a_ack, 0);
        check("mid_rst_mem_we", a_mem_we, 0);
        check("mid_rst_mem_a", a_mem_a, 0);
        check("mid_rst_mem_wd", a_mem_wd, 0);
        check("mid_rst_rd", a_rd, 0);
        a_req = 2'b00; a_we = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        ack_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (|a_ack || a_mem_we) ack_cnt++;
        end
        check("mid_rst_no_ack", ack_cnt, 0);
        check("mid_rst_mem_word", mem_a[8], sh_a[8]);
        a_access(0, 1'b0, 32'h20, 32'h0, ack_cyc, ack_cnt, we_cyc, we_cnt, we_adr, rd_ack, ack_val);
        check("post_rst_ack_cycle", ack_cyc, 5);
        check("post_rst_ack_val", ack_val, 2'b01);
        check("post_rst_rd", rd_ack, 32'h1234_5678);

        // Request dropped and address changed after grant
        a_we = 2'b00;
        a_adr[31:0] = 32'h24;
        a_req = 2'b01;
        @(negedge clk);
        check("drop_gnt", a_gnt, 2'b01);
        a_req = 2'b00;
        a_adr[31:0] = 32'h3C;
        ack_cnt = 0; ack_cyc = -1; rd_ack = '0; n = 0;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            if (c == 4) check("drop_mem_a", a_mem_a, 32'h24);
            if (|a_gnt) n++;
            if (|a_ack) begin
                ack_cnt++;
                ack_cyc = c;
                rd_ack = a_rd;
            end
        end
        check("drop_ack_count", ack_cnt, 1);
        check("drop_ack_cycle", ack_cyc, 5);
        check("drop_rd", rd_ack, sh_a[9]);
        check("drop_gnt_cycles", n, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
